vga_frame_scaler: RTL and testbench



---
 rtl/vga_cam_pkg.sv | 31 +++
 rtl/vga_row_tracker.sv | 66 ++++++
 rtl/vga_frame_scaler.sv | 126 ++++++++++++
 tb/tb_vga_frame_scaler.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_cam_pkg.sv
// Shared constants, pixel type and helpers for the VGA camera read path.
// Used by vga_frame_scaler and vga_row_tracker.
package vga_cam_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    typedef logic [11:0] rgb444_t;

    // Colour bars: index bits 2,1,0 switch the R,G,B nibbles fully on.
    localparam rgb444_t [7:0] BAR_LUT = {
        12'hFFF, 12'hFF0, 12'hF0F, 12'hF00,
        12'h0FF, 12'h0F0, 12'h00F, 12'h000
    };

    function automatic int unsigned blank_addr(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

    function automatic rgb444_t bar_colour(input logic [2:0] idx);
        return BAR_LUT[idx];
    endfunction

    // Last on-screen coordinate of a span that may run past the screen edge.
    function automatic int unsigned clip_last(input int unsigned first,
                                              input int unsigned span,
                                              input int unsigned limit);
        return (first + span > limit) ? limit - 1 : first + span - 1;
    endfunction

endpackage

// File: rtl/vga_row_tracker.sv
// Incremental frame-buffer row base: detects VGA line changes and steps
// row_base by IMG_W every 2^SCALE_LOG2 in-window lines, without a multiplier.
module vga_row_tracker
    import vga_cam_pkg::*;
#(
    parameter int          IMG_W      = 160,
    parameter int          AW         = 15,
    parameter int          SCALE_LOG2 = 2,
    parameter int unsigned Y0         = 0,
    parameter int unsigned Y_SPAN     = 480
)(
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    pos_y,
    output logic [AW-1:0] row_base
);

    localparam logic [2:0] SUB_LAST = 3'((1 << SCALE_LOG2) - 1);

    logic [9:0]  py;
    logic        seen;
    logic        synced;
    logic [2:0]  sub_row;
    logic        line_chg;
    logic        at_top;
    logic        in_rows;
    logic [11:0] dy;

    always_comb begin
        // The first sample after reset always counts as a new line.
        line_chg = !seen || (pos_y != py);
        dy       = {2'b00, pos_y} - 12'(Y0);
        at_top   = (dy == 12'd0);
        in_rows  = !dy[11] && (dy[10:0] <= 11'(Y_SPAN - 1));
    end

    // NOTE: state registers use non-blocking assignments so every flop sees
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            py       <= '0;
            seen     <= 1'b0;
            synced   <= 1'b0;
            sub_row  <= '0;
            row_base <= '0;
        end else begin
            py   <= pos_y;
            seen <= 1'b1;
            if (line_chg) begin
                if (at_top) begin
                    row_base <= '0;
                    sub_row  <= '0;
                    synced   <= 1'b1;
                end else if (synced && in_rows) begin
                    if (sub_row == SUB_LAST) begin
                        sub_row  <= '0;
                        row_base <= row_base + AW'(IMG_W);
                    end else begin
                        sub_row <= sub_row + 3'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/vga_frame_scaler.sv
// Frame-buffer read address generator and pixel aligner for a 640x480 VGA driver.
// Optional colour-bar test pattern is enabled by defining VGA_FRAME_SCALER_TESTPAT_EN.
module vga_frame_scaler
    import vga_cam_pkg::*;
#(
    parameter int             IMG_W      = 160,
    parameter int             IMG_H      = 120,
    parameter int             AW         = 15,
    parameter int             DW         = 12,
    parameter int             SCALE_LOG2 = 2,
    parameter int unsigned    X0         = 0,
    parameter int unsigned    Y0         = 0,
    parameter logic [DW-1:0]  BORDER     = '0
)(
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    vga_posX,
    input  logic [9:0]    vga_posY,
    input  logic [DW-1:0] mem_data,
`ifdef VGA_FRAME_SCALER_TESTPAT_EN
    input  logic          test_en,
`endif
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] pixel_out,
    output logic          pixel_in_win
);

    localparam int unsigned   WIN_W      = IMG_W << SCALE_LOG2;
    localparam int unsigned   WIN_H      = IMG_H << SCALE_LOG2;
    localparam int unsigned   X_SPAN     = clip_last(X0, WIN_W, SCREEN_W) - X0 + 1;
    localparam int unsigned   Y_SPAN     = clip_last(Y0, WIN_H, SCREEN_H) - Y0 + 1;
    localparam logic [AW-1:0] BLANK_ADDR = AW'(blank_addr(IMG_W, IMG_H));

    logic [11:0]   dx0;
    logic [11:0]   dy0;
    logic          in_win;
    logic [9:0]    px0;
    logic          win0;
    logic [AW-1:0] row_base;
    logic [10:0]   dx1;
    logic [10:0]   col_idx;
    logic          win1;
    logic          win2;

    // Window test via borrow of the offset subtraction; both bounds inclusive.
    always_comb begin
        dx0    = {2'b00, vga_posX} - 12'(X0);
        dy0    = {2'b00, vga_posY} - 12'(Y0);
        in_win = !dx0[11] && (dx0[10:0] <= 11'(X_SPAN - 1)) &&
                 !dy0[11] && (dy0[10:0] <= 11'(Y_SPAN - 1));
    end

    vga_row_tracker #(
        .IMG_W      (IMG_W),
        .AW         (AW),
        .SCALE_LOG2 (SCALE_LOG2),
        .Y0         (Y0),
        .Y_SPAN     (Y_SPAN)
    ) u_row_tracker (
        .clk      (clk),
        .rst      (rst),
        .pos_y    (vga_posY),
        .row_base (row_base)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            px0  <= '0;
            win0 <= 1'b0;
        end else begin
            px0  <= vga_posX;
            win0 <= in_win;
        end
    end

    always_comb begin
        dx1     = 11'(px0) - 11'(X0);
        col_idx = dx1 >> SCALE_LOG2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr <= BLANK_ADDR;
            win1     <= 1'b0;
            win2     <= 1'b0;
        end else begin
            mem_addr <= win0 ? (row_base + AW'(col_idx)) : BLANK_ADDR;
            win1     <= win0;
            win2     <= win1;
        end
    end

`ifdef VGA_FRAME_SCALER_TESTPAT_EN
    logic [2:0] bar1;
    logic [2:0] bar2;

    always_ff @(posedge clk) begin
        if (rst) begin
            bar1 <= '0;
            bar2 <= '0;
        end else begin
            bar1 <= col_idx[6:4];
            bar2 <= bar1;
        end
    end
`endif

    // mem_data is already the RAM's output register, so stage 2 only needs
    // win2 registered beside it; the final mux stays combinational.
    // NOTE: pixel_out gets its default first so no path through this block
    // can leave it unassigned and infer a latch.
    always_comb begin
        pixel_out = BORDER;
        if (win2) begin
            pixel_out = mem_data;
`ifdef VGA_FRAME_SCALER_TESTPAT_EN
            if (test_en) begin
                pixel_out = DW'(bar_colour(bar2));
            end
`endif
        end
    end

    assign pixel_in_win = win2;

endmodule

// File: tb/tb_vga_frame_scaler.sv
// Self-checking bench for vga_frame_scaler: two parameterisations driven in lockstep,
// expected addresses and pixels from a multiplier-based model queued per drive.
module tb_vga_frame_scaler;

    localparam int IMG_W = 160;
    localparam int IMG_H = 120;
    localparam int AW    = 15;
    localparam int DW    = 12;
    localparam int BLANK = IMG_W * IMG_H;

    localparam int S_A = 2, X0_A = 0,   Y0_A = 0;
    localparam int S_B = 0, X0_B = 240, Y0_B = 180;
    localparam logic [DW-1:0] BORDER_A = 12'h000;
    localparam logic [DW-1:0] BORDER_B = 12'h5A5;

    logic          clk = 1'b0;
    logic          rst;
    logic [9:0]    pos_x, pos_y;
    logic          test_en;
    logic [DW-1:0] mem_data_a, mem_data_b;
    logic [AW-1:0] mem_addr_a, mem_addr_b;
    logic [DW-1:0] pixel_a, pixel_b;
    logic          win_a, win_b;

    always #20 clk = ~clk;

    vga_frame_scaler #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .DW(DW),
        .SCALE_LOG2(S_A), .X0(X0_A), .Y0(Y0_A), .BORDER(BORDER_A)
    ) dut_a (
        .clk(clk), .rst(rst), .vga_posX(pos_x), .vga_posY(pos_y),
        .mem_data(mem_data_a),
`ifdef VGA_FRAME_SCALER_TESTPAT_EN
        .test_en(test_en),
`endif
        .mem_addr(mem_addr_a), .pixel_out(pixel_a), .pixel_in_win(win_a)
    );

    vga_frame_scaler #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .DW(DW),
        .SCALE_LOG2(S_B), .X0(X0_B), .Y0(Y0_B), .BORDER(BORDER_B)
    ) dut_b (
        .clk(clk), .rst(rst), .vga_posX(pos_x), .vga_posY(pos_y),
        .mem_data(mem_data_b),
`ifdef VGA_FRAME_SCALER_TESTPAT_EN
        .test_en(test_en),
`endif
        .mem_addr(mem_addr_b), .pixel_out(pixel_b), .pixel_in_win(win_b)
    );

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return DW'(32'(a) * 13 + 7);
    endfunction

    // Frame buffers with one clock of read latency.
    always_ff @(posedge clk) begin
        mem_data_a <= mem_word(mem_addr_a);
        mem_data_b <= mem_word(mem_addr_b);
    end

    typedef struct {
        int            due;
        string         tag;
        logic [AW-1:0] addr_a, addr_b;
        logic          win_a, win_b;
        logic [DW-1:0] pix_a, pix_b;
    } exp_t;

    exp_t addr_q[$];
    exp_t pix_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   sync_a, sync_b;

    function automatic bit model_win(input int s, input int x0, input int y0, input int x, input int y);
        return (x >= x0) && (x < x0 + (IMG_W << s)) && (y >= y0) && (y < y0 + (IMG_H << s));
    endfunction

    function automatic logic [AW-1:0] model_addr(input int s, input int x0, input int y0,
                                                 input int x, input int y, input bit synced);
        int row, col;
        if (!model_win(s, x0, y0, x, y)) return AW'(BLANK);
        col = (x - x0) >> s;
        row = synced ? ((y - y0) >> s) : 0;
        return AW'(row * IMG_W + col);
    endfunction

    function automatic logic [DW-1:0] model_bar(input int s, input int x0, input int x);
        logic [2:0] b;
        b = 3'((((x - x0) >> s) >> 4) % 8);
        return {b[2] ? 4'hF : 4'h0, b[1] ? 4'hF : 4'h0, b[0] ? 4'hF : 4'h0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
            e = addr_q.pop_front();
            check({"addr_a_", e.tag}, 32'(mem_addr_a), 32'(e.addr_a));
            check({"addr_b_", e.tag}, 32'(mem_addr_b), 32'(e.addr_b));
        end
        while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
            e = pix_q.pop_front();
            check({"pix_a_", e.tag}, 32'(pixel_a), 32'(e.pix_a));
            check({"win_a_", e.tag}, 32'(win_a),   32'(e.win_a));
            check({"pix_b_", e.tag}, 32'(pixel_b), 32'(e.pix_b));
            check({"win_b_", e.tag}, 32'(win_b),   32'(e.win_b));
        end
    endtask

    task automatic drive(input int x, input int y);
        exp_t e;
        pos_x = 10'(x);
        pos_y = 10'(y);
        if (y == Y0_A) sync_a = 1'b1;
        if (y == Y0_B) sync_b = 1'b1;
        e.tag    = $sformatf("x%0d_y%0d", x, y);
        e.win_a  = model_win(S_A, X0_A, Y0_A, x, y);
        e.win_b  = model_win(S_B, X0_B, Y0_B, x, y);
        e.addr_a = model_addr(S_A, X0_A, Y0_A, x, y, sync_a);
        e.addr_b = model_addr(S_B, X0_B, Y0_B, x, y, sync_b);
        e.pix_a  = !e.win_a ? BORDER_A : (test_en ? model_bar(S_A, X0_A, x) : mem_word(e.addr_a));
        e.pix_b  = !e.win_b ? BORDER_B : (test_en ? model_bar(S_B, X0_B, x) : mem_word(e.addr_b));
        e.due = cyc + 2;
        addr_q.push_back(e);
        e.due = cyc + 3;
        pix_q.push_back(e);
        tick();
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        addr_q.delete();
        pix_q.delete();
        sync_a = 1'b0;
        sync_b = 1'b0;
        tick();
        check({"rst_addr_a_", tag}, 32'(mem_addr_a), 32'(BLANK));
        check({"rst_addr_b_", tag}, 32'(mem_addr_b), 32'(BLANK));
        check({"rst_pix_a_", tag},  32'(pixel_a),    32'(BORDER_A));
        check({"rst_pix_b_", tag},  32'(pixel_b),    32'(BORDER_B));
        check({"rst_win_a_", tag},  32'(win_a),      32'(0));
        check({"rst_win_b_", tag},  32'(win_b),      32'(0));
        rst = 1'b0;
    endtask

    function automatic int pick_x(input int y);
        case (y)
            9:       return 5;
            180:     return 240;
            200:     return 239;
            299:     return 399;
            479:     return 639;
            default: return (y * 37 + 11) % 640;
        endcase
    endfunction

    initial begin
        rst     = 1'b1;
        pos_x   = '0;
        pos_y   = '0;
        test_en = 1'b0;
        sync_a  = 1'b0;
        sync_b  = 1'b0;
        tick();
        pulse_reset("power_up");

        // Full frame, one sample per line, including the window corners of both DUTs.
        for (int y = 0; y < 480; y++) begin
            drive(pick_x(y), y);
            if (y == 200) drive(400, 200);
        end

        // Frame wrap 479 -> 0 must restart the row base.
        for (int y = 0; y <= 250; y++) begin
            drive((y * 53 + 3) % 640, y);
        end

        // Mid-frame reset: rows stay at base 0 until the next top line.
        pulse_reset("mid_frame");
        for (int y = 251; y < 480; y++) begin
            drive((y * 29 + 7) % 640, y);
        end
        for (int y = 0; y <= 12; y++) begin
            drive((y == 9) ? 5 : y * 4, y);
        end
        for (int y = 13; y <= 200; y++) begin
            drive((y == 180) ? 240 : (y * 41 + 1) % 640, y);
        end

`ifdef VGA_FRAME_SCALER_TESTPAT_EN
        test_en = 1'b1;
        drive(64, 201);
        drive(300, 201);
        drive(639, 201);
        for (int i = 0; i < 4; i++) tick();
        test_en = 1'b0;
`endif

        for (int i = 0; i < 4; i++) tick();
        checks++;
        assert (addr_q.size() == 0 && pix_q.size() == 0) else begin
            failures++;
            $error("FAIL drain observed=%0d expected=0", addr_q.size() + pix_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
